// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and the write-request record for the register
//               file write buffer.
//               DATA_WIDTH - register data width
//               ADDR_WIDTH - register address width
//               wr_req_t   - {addr, data} write request
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;

    typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [DATA_WIDTH-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wr_req_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_buffer_if
// Description : Request channel (valid/ready) into the write buffer plus the
//               registered write port it drives toward the register file.
//               in_valid/in_ready/in_addr/in_data        - request handshake
//               rf_write_en/rf_write_addr/rf_write_data  - RF write port
//               modport slave  : the write buffer
//               modport master : the requester / RF-side observer
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_buffer_if;
    import regfile_pkg::*;

    logic     in_valid;
    logic     in_ready;
    rf_addr_t in_addr;
    rf_data_t in_data;

    logic     rf_write_en;
    rf_addr_t rf_write_addr;
    rf_data_t rf_write_data;

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready,
        output rf_write_en,
        output rf_write_addr,
        output rf_write_data
    );

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready,
        input  rf_write_en,
        input  rf_write_addr,
        input  rf_write_data
    );

endinterface : regfile_write_buffer_if
`default_nettype wire

// File: rtl/wb_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo_core
// Description : DEPTH-entry circular FIFO of write requests. Pointers wrap
//               naturally modulo DEPTH; full/empty are derived from count.
//               Storage and read pointer are exported so the parent can
//               search pending entries.
// Ports       : clk, rst      - clock, async active-high reset
//               push_i/wr_req_i - enqueue request (ignored when full)
//               pop_i         - dequeue head (ignored when empty)
//               head_o        - oldest entry
//               mem_o/rd_ptr_o/count_o - storage view for lookup
//               empty_o/full_o - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo_core
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  wr_req_t               wr_req_i,
    input  logic                  pop_i,
    output wr_req_t               head_o,
    output wr_req_t [DEPTH-1:0]   mem_o,
    output logic [PTR_W-1:0]      rd_ptr_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    wr_req_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Local guards keep the core self-consistent even if the parent
    // requests an illegal operation.
    assign do_push = push_i && (count_q != FULL_COUNT);
    assign do_pop  = pop_i  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_req_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o   = mem_q[rd_ptr_q];
    assign mem_o    = mem_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_COUNT);

endmodule : wb_fifo_core
`default_nettype wire

// File: rtl/regfile_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_buffer
// Description : Write-side staging buffer for the register file. Requests are
//               queued in a FIFO and drained one per cycle into a registered
//               RF write port while enable is high. A combinational lookup
//               returns the youngest pending data for an address so readers
//               can forward around writes not yet committed.
// Ports       : clk, rst      - clock, async active-high reset
//               bus (slave)   - request handshake + RF write port
//               enable        - drain permission
//               lookup_addr   - address probed for pending data
//               lookup_hit    - pending write exists for lookup_addr
//               lookup_data   - youngest pending data (0 on miss)
//               count         - entries queued, excluding output register
//               empty / full  - queue status
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_buffer_if.slave  bus,
    input  logic                   enable,
    input  rf_addr_t               lookup_addr,
    output logic                   lookup_hit,
    output rf_data_t               lookup_data,
    output logic [CNT_W-1:0]       count,
    output logic                   empty,
    output logic                   full
);

    logic                push;
    logic                pop;
    wr_req_t             head;
    wr_req_t [DEPTH-1:0] fifo_mem;
    logic [PTR_W-1:0]    fifo_rd_ptr;
    logic [PTR_W-1:0]    lk_idx;

    logic                rf_en_q;
    rf_addr_t            rf_addr_q;
    rf_data_t            rf_data_q;

    // Ready is held low while reset is asserted so nothing is accepted
    // into a queue that is being cleared.
    assign bus.in_ready = !full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    // Pop sees only entries already stored: a request accepted this edge
    // cannot also leave this edge.
    assign pop          = enable && !empty;

    wb_fifo_core #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .wr_req_i ('{addr: bus.in_addr, data: bus.in_data}),
        .pop_i    (pop),
        .head_o   (head),
        .mem_o    (fifo_mem),
        .rd_ptr_o (fifo_rd_ptr),
        .count_o  (count),
        .empty_o  (empty),
        .full_o   (full)
    );

    // Output register: pulses rf_write_en for one cycle per popped entry;
    // address/data hold their last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_en_q <= pop;
            if (pop) begin
                rf_addr_q <= head.addr;
                rf_data_q <= head.data;
            end
        end
    end

    assign bus.rf_write_en   = rf_en_q;
    assign bus.rf_write_addr = rf_addr_q;
    assign bus.rf_write_data = rf_data_q;

    // Lookup priority: the output register is considered first, then the
    // valid FIFO entries are scanned oldest to youngest so that the last
    // match (the youngest entry) overrides everything before it.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        if (rf_en_q && (rf_addr_q == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = rf_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = fifo_rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (fifo_mem[lk_idx].addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = fifo_mem[lk_idx].data;
            end
        end
    end

endmodule : regfile_write_buffer
`default_nettype wire
